// File: rtl/smoke_bfm_pipe_pkg.sv
// smoke_bfm_pipe_pkg: shared widths, output-register states and the increment helper.
// SMOKE_BFM_PIPE_SAT_EN selects a saturating increment instead of wrap-around.
package smoke_bfm_pipe_pkg;
  localparam int CNT_WIDTH = 16;
  localparam int MAX_WIDTH = 64;
  typedef enum logic {O_EMPTY, O_FULL} out_state_t;
  function automatic int chan_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  // Operands arrive zero-extended to MAX_WIDTH; width selects the live result bits.
  function automatic logic [MAX_WIDTH:0] inc_calc(input logic [MAX_WIDTH-1:0] data, input logic [MAX_WIDTH-1:0] step, input int width);
    logic [MAX_WIDTH:0] sum;
    logic [MAX_WIDTH-1:0] mask;
    logic ovf;
    sum = {1'b0, data} + {1'b0, step};
    mask = {MAX_WIDTH{1'b1}} >> (MAX_WIDTH - width);
    ovf = |(sum & ~{1'b0, mask});
`ifdef SMOKE_BFM_PIPE_SAT_EN
    return {ovf, ovf ? mask : (sum[MAX_WIDTH-1:0] & mask)};
`else
    return {ovf, sum[MAX_WIDTH-1:0] & mask};
`endif
  endfunction
endpackage

// File: rtl/smoke_bfm_fifo.sv
// smoke_bfm_fifo: synchronous FIFO with occupancy count, full and empty flags.
module smoke_bfm_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  assign rdata = mem[rptr];
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop) rptr <= rptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clock) if (push) mem[wptr] <= wdata;
endmodule

// File: rtl/smoke_bfm_pipe.sv
// smoke_bfm_pipe: multi-channel increment pipe (FIFO -> compute stage -> output register) with per-channel counters.
// Define SMOKE_BFM_PIPE_SAT_EN for saturating results on carry-out.
module smoke_bfm_pipe import smoke_bfm_pipe_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  parameter int N_CHANNELS = 4,
  parameter int FIFO_DEPTH = 4,
  parameter logic [DATA_WIDTH-1:0] STEP = 1,
  localparam int CW = chan_width(N_CHANNELS)
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [CW-1:0]                  req_chan,
  input  logic [DATA_WIDTH-1:0]          req_data,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [CW-1:0]                  rsp_chan,
  output logic [DATA_WIDTH-1:0]          rsp_data,
  output logic                           rsp_ovf,
  output logic                           rsp_err,
  output logic [N_CHANNELS*CNT_WIDTH-1:0] done_cnt,
  output logic                           idle
);
  localparam int QW = $clog2(FIFO_DEPTH) + 1;
  logic push, pop, f_full, f_empty, s_valid, s_adv, s_err, s_next, o_next, calc_ovf, rsp_hs;
  logic [CW+DATA_WIDTH-1:0] head;
  logic [QW-1:0] f_count, cnt_next;
  logic [CW-1:0] s_chan;
  logic [DATA_WIDTH-1:0] s_data, calc_res;
  logic [MAX_WIDTH:0] calc;
  out_state_t ostate;
  smoke_bfm_fifo #(.WIDTH(CW + DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clock(clock), .reset_n(reset_n), .push(push), .pop(pop),
    .wdata({req_chan, req_data}), .rdata(head), .count(f_count), .full(f_full), .empty(f_empty)
  );
  assign req_ready = !f_full;
  assign push = req_valid && req_ready;
  assign rsp_valid = ostate == O_FULL;
  assign rsp_hs = rsp_valid && rsp_ready;
  assign s_adv = s_valid && (!rsp_valid || rsp_ready);
  assign pop = !f_empty && (!s_valid || s_adv);
  assign s_err = 32'(s_chan) >= N_CHANNELS;
  assign calc = inc_calc(MAX_WIDTH'(s_data), MAX_WIDTH'(STEP), DATA_WIDTH);
  assign calc_ovf = calc[MAX_WIDTH];
  assign calc_res = calc[DATA_WIDTH-1:0];
  always_ff @(posedge clock) begin
    if (!reset_n) s_valid <= 1'b0;
    else if (pop) s_valid <= 1'b1;
    else if (s_adv) s_valid <= 1'b0;
  end
  always_ff @(posedge clock) if (pop) {s_chan, s_data} <= head;
  // Output register: loads whenever the stage advances, otherwise empties on handshake.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ostate <= O_EMPTY;
      rsp_chan <= '0;
      rsp_data <= '0;
      rsp_ovf <= 1'b0;
      rsp_err <= 1'b0;
    end else if (s_adv) begin
      ostate <= O_FULL;
      rsp_chan <= s_chan;
      rsp_err <= s_err;
      rsp_data <= s_err ? s_data : calc_res;
      rsp_ovf <= !s_err && calc_ovf;
    end else if (rsp_ready) ostate <= O_EMPTY;
  end
  for (genvar i = 0; i < N_CHANNELS; i++) begin : g_cnt
    logic [CNT_WIDTH-1:0] c;
    always_ff @(posedge clock) begin
      if (!reset_n) c <= '0;
      else if (rsp_hs && !rsp_err && rsp_chan == CW'(i)) c <= c + CNT_WIDTH'(1);
    end
    assign done_cnt[CNT_WIDTH*i +: CNT_WIDTH] = c;
  end
  // idle reflects the occupancy that the coming edge leaves behind.
  assign cnt_next = f_count + QW'(push) - QW'(pop);
  assign s_next = pop || (s_valid && !s_adv);
  assign o_next = s_adv || (rsp_valid && !rsp_ready);
  always_ff @(posedge clock) begin
    if (!reset_n) idle <= 1'b1;
    else idle <= cnt_next == '0 && !s_next && !o_next;
  end
endmodule

// File: tb/tb_smoke_bfm_pipe.sv
// tb_smoke_bfm_pipe: directed and randomized checks of smoke_bfm_pipe against an in-order response model.
module tb_smoke_bfm_pipe;
  localparam int NC = 3;
  localparam logic [31:0] STEP = 1;
  typedef struct packed {logic [1:0] chan; logic err; logic ovf; logic [31:0] data;} rsp_t;
  logic clock = 0, reset_n = 0, req_valid = 0, rsp_ready = 0;
  logic [1:0] req_chan = 0;
  logic [31:0] req_data = 0;
  logic req_ready, rsp_valid, rsp_ovf, rsp_err, idle;
  logic [1:0] rsp_chan;
  logic [31:0] rsp_data;
  logic [47:0] done_cnt;
  rsp_t q[$];
  logic [15:0] cnt [NC];
  int checks = 0, failures = 0, acc, n;
  smoke_bfm_pipe #(.DATA_WIDTH(32), .N_CHANNELS(NC), .FIFO_DEPTH(4), .STEP(STEP)) dut (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_chan(req_chan), .req_data(req_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_chan(rsp_chan), .rsp_data(rsp_data), .rsp_ovf(rsp_ovf), .rsp_err(rsp_err),
    .done_cnt(done_cnt), .idle(idle)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic rsp_t expect_rsp(input logic [1:0] ch, input logic [31:0] d);
    rsp_t r;
    longint unsigned s;
    s = longint'(d) + longint'(STEP);
    r.chan = ch;
    r.err = ch >= NC;
    r.ovf = !r.err && s >= 64'h1_0000_0000;
`ifdef SMOKE_BFM_PIPE_SAT_EN
    r.data = r.err ? d : r.ovf ? 32'hFFFF_FFFF : s[31:0];
`else
    r.data = r.err ? d : s[31:0];
`endif
    return r;
  endfunction
  // Handshakes are decided by the values visible now; advance one clock and recheck counters.
  task automatic cycle();
    rsp_t e;
    if (req_valid && req_ready) q.push_back(expect_rsp(req_chan, req_data));
    if (rsp_valid && rsp_ready) begin
      if (q.size() == 0) chk("rsp_unexpected", 1, 0);
      else begin
        e = q.pop_front();
        chk("rsp_chan", rsp_chan, e.chan);
        chk("rsp_err", rsp_err, e.err);
        chk("rsp_ovf", rsp_ovf, e.ovf);
        chk("rsp_data", rsp_data, e.data);
        if (!e.err) cnt[e.chan] = cnt[e.chan] + 16'd1;
      end
    end
    @(posedge clock);
    @(negedge clock);
    chk("done_cnt", done_cnt, {cnt[2], cnt[1], cnt[0]});
  endtask
  task automatic do_reset();
    reset_n = 0;
    req_valid = 0;
    rsp_ready = 0;
    @(posedge clock);
    @(negedge clock);
    reset_n = 1;
    q.delete();
    foreach (cnt[i]) cnt[i] = 0;
  endtask
  task automatic check_reset_vals(input string tag);
    chk({tag, "_req_ready"}, req_ready, 1);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_chan"}, rsp_chan, 0);
    chk({tag, "_rsp_data"}, rsp_data, 0);
    chk({tag, "_rsp_ovf"}, rsp_ovf, 0);
    chk({tag, "_rsp_err"}, rsp_err, 0);
    chk({tag, "_done_cnt"}, done_cnt, 0);
    chk({tag, "_idle"}, idle, 1);
  endtask
  task automatic drain(input int budget);
    int k = 0;
    req_valid = 0;
    rsp_ready = 1;
    while (q.size() != 0 && k < budget) begin
      cycle();
      k++;
    end
    chk("drain_left", q.size(), 0);
    chk("drain_idle", idle, 1);
  endtask
  initial begin
    #1_500_000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end
  initial begin
    @(negedge clock);
    do_reset();
    check_reset_vals("reset");
    req_valid = 1; req_chan = 2; req_data = 5; rsp_ready = 1;
    cycle();
    req_valid = 0;
    chk("lat_k_valid", rsp_valid, 0);
    chk("lat_k_idle", idle, 0);
    cycle();
    chk("lat_k1_valid", rsp_valid, 0);
    cycle();
    chk("lat_k2_valid", rsp_valid, 1);
    chk("lat_k2_chan", rsp_chan, 2);
    chk("lat_k2_data", rsp_data, 6);
    chk("lat_k2_ovf", rsp_ovf, 0);
    chk("lat_k2_err", rsp_err, 0);
    cycle();
    chk("lat_cnt2", done_cnt[47:32], 1);
    chk("lat_idle", idle, 1);
    rsp_ready = 0;
    acc = 0;
    for (int i = 0; i < 7; i++) begin
      req_valid = 1; req_chan = 2'(i % 3); req_data = 32'(100 + i);
      if (req_ready) acc++;
      cycle();
    end
    req_valid = 0;
    chk("bp_accepted", acc, 6);
    chk("bp_req_ready", req_ready, 0);
    chk("bp_hold_data", rsp_data, 101);
    rsp_ready = 1;
    for (int i = 0; i < 6; i++) begin
      chk("bp_stream_valid", rsp_valid, 1);
      cycle();
    end
    chk("bp_after_valid", rsp_valid, 0);
    req_valid = 1; req_chan = 0; req_data = 32'hFFFF_FFFF;
    cycle();
    req_valid = 0;
    cycle();
    cycle();
    chk("ovf_flag", rsp_ovf, 1);
`ifdef SMOKE_BFM_PIPE_SAT_EN
    chk("ovf_data", rsp_data, 32'hFFFF_FFFF);
`else
    chk("ovf_data", rsp_data, 0);
`endif
    cycle();
    req_valid = 1; req_chan = 3; req_data = 9;
    cycle();
    req_valid = 0;
    cycle();
    cycle();
    chk("illegal_err", rsp_err, 1);
    chk("illegal_data", rsp_data, 9);
    chk("illegal_ovf", rsp_ovf, 0);
    cycle();
    for (int i = 0; i < 400; i++) begin
      req_valid = $urandom_range(0, 9) < 6;
      rsp_ready = $urandom_range(0, 9) < 6;
      req_chan = 2'($urandom_range(0, 3));
      req_data = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 1)) : 32'($urandom);
      cycle();
    end
    drain(100);
    rsp_ready = 0;
    for (int i = 0; i < 3; i++) begin
      req_valid = 1; req_chan = 1; req_data = 32'(i);
      cycle();
    end
    do_reset();
    check_reset_vals("flush");
    rsp_ready = 1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("flush_valid", rsp_valid, 0);
      chk("flush_idle", idle, 1);
    end
    acc = 0;
    n = 0;
    req_chan = 0;
    while (acc < 65536 && n < 70000) begin
      req_valid = 1;
      req_data = 32'(acc);
      if (req_ready) acc++;
      cycle();
      n++;
    end
    chk("wrap_accepted", acc, 65536);
    drain(20);
    chk("wrap_cnt0", done_cnt[15:0], 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
